uart_xcvr: RTL and testbench
============================

Name: uart_xcvr

Overview:
- Parametrised UART transceiver that supersedes the fixed 8N1 interface used by the echo device.
- Supports configurable data bits, parity mode, stop bits, and clock/baud ratio.
- Detects RX parity and framing errors, rejects start-bit glitches, and has a runtime internal loopback mode.
- Sits between the board UART pins and cmd_parser / TX FIFO, keeping the existing 1-clk irq-pulse handshake.

Parameters:
- SYS_CLK_FREQ, 50000000, system clock in Hz.
- BAUD_RATE, 115200, line rate. DIV = SYS_CLK_FREQ/BAUD_RATE, truncated; 434 by default. Counter width = $clog2(DIV).
- DATA_BITS, 8, payload bits per frame. Legal range 5..8.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits transmitted: 1 or 2. RX checks only the first stop bit.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous, active-low reset.
- uart_rx_i  in  1  serial input, asynchronous to clk_i.
- uart_tx_o  out  1  serial output, idle high.
- loopback_i  in  1  1 routes the internal TX line to the RX path.
- rx_irq_o  out  1  1-clk pulse: frame received.
- rx_data_o  out  8  received payload, LSB-aligned, upper bits zero.
- rx_perr_o  out  1  parity error flag, valid with rx_irq_o.
- rx_ferr_o  out  1  framing error flag, valid with rx_irq_o.
- tx_irq_i  in  1  1-clk pulse: send tx_data_i.
- tx_data_i  in  8  payload; bits above DATA_BITS-1 are ignored.
- tx_busy_o  out  1  1 means tx_irq_i is ignored.

Behaviour:
- Reset:
  - uart_tx_o=1; all other outputs 0.
  - Both FSMs go to IDLE and counters clear.
  - A reset mid-frame aborts immediately; the line returns high, with no partial pulse.
- RX input path:
  - uart_rx_i passes through a 2-FF synchroniser (reset value 1).
  - The effective input is the TX serial line when loopback is active, else the synchronised pin.
- RX FSM, states IDLE, START, DATA, PARITY, STOP:
  - IDLE: on a falling edge of the effective input, load the counter and go to START.
  - START: at DIV/2 clocks, resample. If the line is high, it is a glitch: return to IDLE with no pulse. Otherwise restart the counter.
  - DATA: sample every DIV clocks, LSB first, DATA_BITS samples.
  - PARITY (skipped when PARITY=0): one sample. Set perr if data XOR parity bit mismatches the mode (odd: total ones odd; even: total ones even).
  - STOP: one sample. A 0 sets ferr. rx_irq_o pulses for one clock together with rx_data_o and both flags, then the FSM returns to IDLE.
  - A frame with errors still delivers its data.
  - rx_data_o and the flags hold until the next pulse.
  - The FSM is ready for a new start edge the clock after STOP; there is no dead time for the second stop bit.
- TX FSM, states IDLE, START, DATA, PARITY, STOP:
  - tx_irq_i is accepted only when tx_busy_o=0. Accepting captures the data; on the next edge, tx_busy_o=1 and uart_tx_o=0.
  - Each bit lasts DIV clocks: DATA_BITS data bits LSB first, then the parity bit if enabled, then STOP_BITS×DIV high.
  - tx_busy_o falls on the edge where the last stop bit ends.
  - An irq in that same cycle is ignored, since busy is still 1. An irq on the next cycle starts the following frame back-to-back.
  - Total busy time = DIV×(1+DATA_BITS+(PARITY!=0)+STOP_BITS) clocks.
  - tx_irq_i while busy is dropped; the data in flight is unchanged.
- Loopback:
  - loopback_i is latched into an internal mode bit only while both FSMs are in IDLE. Mid-frame changes are deferred.
  - While in loopback mode, uart_tx_o is forced to 1 and uart_rx_i is ignored.

Optional Feature:
- Macro UART_XCVR_BREAK_DET_EN.
- When defined:
  - adds output rx_break_o.
  - A frame whose data bits are all 0 and whose stop bit is 0 sets rx_break_o=1 instead of pulsing rx_irq_o.
  - The RX FSM then waits until the line has been high for DIV consecutive clocks before re-entering IDLE; rx_break_o clears on that transition.
- When undefined:
  - the port is absent.
  - Such a frame is delivered as data 0x00 with ferr=1.

Test Plan:
- Default 8N1: send 0xA5 on uart_rx_i at DIV=434 -> one rx_irq_o pulse with rx_data_o=0xA5, perr=0, ferr=0. TX 0x3C -> uart_tx_o bit pattern 0,0,0,1,1,1,1,0,0,1, busy for exactly 4340 clocks.
- PARITY=2, DATA_BITS=7: RX 0x41 with parity bit 1 -> perr=1, data 0x41. Parity bit 0 -> perr=0. TX 0x41 -> parity bit 0.
- Glitch and framing: a low pulse of DIV/4 clocks produces no irq. A frame 0x55 with stop=0 -> rx_irq_o with ferr=1, data 0x55.
- Busy handshake: tx_irq_i (0x11) followed by tx_irq_i (0x22) 100 clocks later -> only 0x11 is sent. Re-issue 0x22 the cycle after busy falls -> back-to-back frames with no idle gap. STOP_BITS=2 -> busy lasts 4774 clocks.
- Loopback: loopback_i=1 in idle, TX 0x7E -> rx_irq_o with 0x7E and uart_tx_o stays 1. Toggle loopback_i mid-frame -> the current frame completes unaffected.
- Reset: assert rst_ni mid-TX at bit 4 -> uart_tx_o=1 and busy=0 immediately. After release, a new frame transmits correctly.

Source files
------------

// File: rtl/uart_xcvr.sv
// uart_xcvr: parametrised UART transceiver (configurable data bits, parity,
// stop bits and clock/baud ratio) with RX parity/framing error detection,
// start-bit glitch rejection and a runtime internal loopback mode.
//
// Ports:
//   clk_i       system clock
//   rst_ni      asynchronous active-low reset
//   uart_rx_i   serial input (asynchronous, synchronised internally)
//   uart_tx_o   serial output, idle high (held high in loopback mode)
//   loopback_i  1 = route internal TX line to the RX path (applied when idle)
//   rx_irq_o    1-clk pulse: frame received
//   rx_data_o   received payload, LSB-aligned, upper bits zero
//   rx_perr_o   parity error flag, valid with rx_irq_o
//   rx_ferr_o   framing error flag, valid with rx_irq_o
//   rx_break_o  break condition (only with UART_XCVR_BREAK_DET_EN)
//   tx_irq_i    1-clk pulse: send tx_data_i
//   tx_data_i   payload; bits above DATA_BITS-1 are ignored
//   tx_busy_o   1 = frame in flight, tx_irq_i ignored
//
// Optional feature: define UART_XCVR_BREAK_DET_EN to add rx_break_o. An
// all-zero frame with a low stop bit then raises rx_break_o instead of
// pulsing rx_irq_o, and RX waits for DIV consecutive high clocks before
// returning to idle.
//
// TX handshake: tx_irq_i is the valid strobe and ~tx_busy_o is ready; a
// byte transfers on a clock where both are 1. A strobe with ready low is
// dropped and never queued.
module uart_xcvr #(
   parameter int SYS_CLK_FREQ = 50000000,
   parameter int BAUD_RATE    = 115200,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       uart_rx_i,
   output logic       uart_tx_o,
   input  logic       loopback_i,
   output logic       rx_irq_o,
   output logic [7:0] rx_data_o,
   output logic       rx_perr_o,
   output logic       rx_ferr_o,
`ifdef UART_XCVR_BREAK_DET_EN
   output logic       rx_break_o,
`endif
   input  logic       tx_irq_i,
   input  logic [7:0] tx_data_i,
   output logic       tx_busy_o
);

   localparam int DIV = SYS_CLK_FREQ / BAUD_RATE;
   localparam int CW  = $clog2(DIV);
   localparam logic [CW-1:0] DIV_M1    = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_M1   = CW'(DIV / 2 - 1);
   localparam logic [7:0]    DMASK     = 8'((1 << DATA_BITS) - 1);
   localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);
   localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
   } rx_state_e;
   typedef enum logic [2:0] {
      TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
   } tx_state_e;

   rx_state_e rx_state_q, rx_state_d;
   tx_state_e tx_state_q, tx_state_d;

   logic [1:0]    rx_sync_q;
   logic          rx_prev_q, loop_q, loop_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
   logic [2:0]    rx_bit_q, rx_bit_d, tx_bit_q, tx_bit_d;
   logic [7:0]    rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
   logic          rx_par_q, rx_par_d;
   logic          rx_irq_q, rx_irq_d;
   logic [7:0]    rx_data_q, rx_data_d;
   logic          rx_perr_q, rx_perr_d, rx_ferr_q, rx_ferr_d;
   logic          rx_break_q, rx_break_d;
   logic          tx_stop_q, tx_stop_d;
   logic          tx_par_q, tx_par_d;
   logic          tx_line_q, tx_line_d;

   logic          rx_in_w, rx_is_break_w, rx_par_err_w;
   logic [7:0]    tx_data_m;

   // In loopback the RX path sees the raw internal TX line (same clock
   // domain, so no synchroniser needed).
   assign rx_in_w   = loop_q ? tx_line_q : rx_sync_q[1];
   assign uart_tx_o = loop_q | tx_line_q;
   assign tx_data_m = tx_data_i & DMASK;
   assign tx_busy_o = (tx_state_q != TX_IDLE);

   assign rx_irq_o  = rx_irq_q;
   assign rx_data_o = rx_data_q;
   assign rx_perr_o = rx_perr_q;
   assign rx_ferr_o = rx_ferr_q;

   // Odd mode wants an odd total of ones over data plus parity bit.
   assign rx_par_err_w = (PARITY != 0) && ((^rx_shift_q ^ rx_par_q) != (PARITY == 1));

`ifdef UART_XCVR_BREAK_DET_EN
   assign rx_is_break_w = (rx_shift_q == 8'h00) && !rx_in_w;
   assign rx_break_o    = rx_break_q;
`else
   assign rx_is_break_w = 1'b0;
`endif

   // Mode changes only take effect when neither direction is mid-frame.
   always_comb begin
      loop_d = loop_q;
      if (rx_state_q == RX_IDLE && tx_state_q == TX_IDLE) loop_d = loopback_i;
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_par_d   = rx_par_q;
      rx_irq_d   = 1'b0;
      rx_data_d  = rx_data_q;
      rx_perr_d  = rx_perr_q;
      rx_ferr_d  = rx_ferr_q;
      rx_break_d = rx_break_q;
      if (rx_state_q != RX_IDLE && rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - 1'b1;
      case (rx_state_q)
         RX_IDLE: begin
            if (rx_prev_q && !rx_in_w) begin
               rx_state_d = RX_START;
               rx_cnt_d   = HALF_M1;
               rx_shift_d = '0;
               rx_bit_d   = '0;
            end
         end
         RX_START: begin
            if (rx_cnt_q == '0) begin
               if (rx_in_w) begin
                  rx_state_d = RX_IDLE;   // start bit did not hold: glitch
               end else begin
                  rx_state_d = RX_DATA;
                  rx_cnt_d   = DIV_M1;
               end
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == '0) begin
               rx_shift_d[rx_bit_q] = rx_in_w;
               rx_cnt_d = DIV_M1;
               if (rx_bit_q == LAST_BIT) begin
                  rx_state_d = (PARITY != 0) ? RX_PARITY : RX_STOP;
               end else begin
                  rx_bit_d = rx_bit_q + 3'd1;
               end
            end
         end
         RX_PARITY: begin
            if (rx_cnt_q == '0) begin
               rx_par_d   = rx_in_w;
               rx_state_d = RX_STOP;
               rx_cnt_d   = DIV_M1;
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == '0) begin
               if (rx_is_break_w) begin
                  rx_state_d = RX_BREAK;
                  rx_cnt_d   = DIV_M1;
                  rx_break_d = 1'b1;
               end else begin
                  rx_state_d = RX_IDLE;
                  rx_irq_d   = 1'b1;
                  rx_data_d  = rx_shift_q;
                  rx_perr_d  = rx_par_err_w;
                  rx_ferr_d  = !rx_in_w;
               end
            end
         end
         RX_BREAK: begin
            // Counter measures consecutive high clocks; any low restarts it.
            if (!rx_in_w) begin
               rx_cnt_d = DIV_M1;
            end else if (rx_cnt_q == '0) begin
               rx_state_d = RX_IDLE;
               rx_break_d = 1'b0;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_stop_d  = tx_stop_q;
      tx_par_d   = tx_par_q;
      tx_line_d  = tx_line_q;
      if (tx_state_q != TX_IDLE && tx_cnt_q != '0) tx_cnt_d = tx_cnt_q - 1'b1;
      case (tx_state_q)
         TX_IDLE: begin
            if (tx_irq_i) begin
               tx_state_d = TX_START;
               tx_shift_d = tx_data_m;
               tx_par_d   = (PARITY == 1) ? ~^tx_data_m : ^tx_data_m;
               tx_line_d  = 1'b0;
               tx_cnt_d   = DIV_M1;
            end
         end
         TX_START: begin
            if (tx_cnt_q == '0) begin
               tx_state_d = TX_DATA;
               tx_line_d  = tx_shift_q[0];
               tx_shift_d = tx_shift_q >> 1;
               tx_bit_d   = '0;
               tx_cnt_d   = DIV_M1;
            end
         end
         TX_DATA: begin
            if (tx_cnt_q == '0) begin
               tx_cnt_d = DIV_M1;
               if (tx_bit_q == LAST_BIT) begin
                  if (PARITY != 0) begin
                     tx_state_d = TX_PARITY;
                     tx_line_d  = tx_par_q;
                  end else begin
                     tx_state_d = TX_STOP;
                     tx_line_d  = 1'b1;
                     tx_stop_d  = 1'b0;
                  end
               end else begin
                  tx_bit_d   = tx_bit_q + 3'd1;
                  tx_line_d  = tx_shift_q[0];
                  tx_shift_d = tx_shift_q >> 1;
               end
            end
         end
         TX_PARITY: begin
            if (tx_cnt_q == '0) begin
               tx_state_d = TX_STOP;
               tx_line_d  = 1'b1;
               tx_stop_d  = 1'b0;
               tx_cnt_d   = DIV_M1;
            end
         end
         TX_STOP: begin
            if (tx_cnt_q == '0) begin
               if (tx_stop_q == LAST_STOP) begin
                  tx_state_d = TX_IDLE;
               end else begin
                  tx_stop_d = tx_stop_q + 1'b1;
                  tx_cnt_d  = DIV_M1;
               end
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_sync_q  <= 2'b11;
         rx_prev_q  <= 1'b1;
         loop_q     <= 1'b0;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_par_q   <= 1'b0;
         rx_irq_q   <= 1'b0;
         rx_data_q  <= '0;
         rx_perr_q  <= 1'b0;
         rx_ferr_q  <= 1'b0;
         rx_break_q <= 1'b0;
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_stop_q  <= 1'b0;
         tx_par_q   <= 1'b0;
         tx_line_q  <= 1'b1;
      end else begin
         rx_sync_q  <= {rx_sync_q[0], uart_rx_i};
         rx_prev_q  <= rx_in_w;
         loop_q     <= loop_d;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_par_q   <= rx_par_d;
         rx_irq_q   <= rx_irq_d;
         rx_data_q  <= rx_data_d;
         rx_perr_q  <= rx_perr_d;
         rx_ferr_q  <= rx_ferr_d;
         rx_break_q <= rx_break_d;
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_stop_q  <= tx_stop_d;
         tx_par_q   <= tx_par_d;
         tx_line_q  <= tx_line_d;
      end
   end

endmodule

// File: tb/tb_uart_xcvr.sv
// Testbench for uart_xcvr. Unit 0 is the default 8N1 build, unit 1 is a
// 7-data-bit, even-parity, 2-stop-bit build; both run at DIV=434.
module tb_uart_xcvr;

   localparam int DIV = 434;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #10 clk = ~clk;
   logic rst_n;

   logic [1:0]      uart_rx, uart_tx, loopback, rx_irq, rx_perr, rx_ferr, tx_irq, tx_busy;
   logic [1:0][7:0] rx_data, tx_data;
`ifdef UART_XCVR_BREAK_DET_EN
   logic [1:0]      rx_break;
`endif

   uart_xcvr u_a (
      .clk_i(clk), .rst_ni(rst_n), .uart_rx_i(uart_rx[0]), .uart_tx_o(uart_tx[0]),
      .loopback_i(loopback[0]), .rx_irq_o(rx_irq[0]), .rx_data_o(rx_data[0]),
      .rx_perr_o(rx_perr[0]), .rx_ferr_o(rx_ferr[0]),
`ifdef UART_XCVR_BREAK_DET_EN
      .rx_break_o(rx_break[0]),
`endif
      .tx_irq_i(tx_irq[0]), .tx_data_i(tx_data[0]), .tx_busy_o(tx_busy[0])
   );

   uart_xcvr #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_b (
      .clk_i(clk), .rst_ni(rst_n), .uart_rx_i(uart_rx[1]), .uart_tx_o(uart_tx[1]),
      .loopback_i(loopback[1]), .rx_irq_o(rx_irq[1]), .rx_data_o(rx_data[1]),
      .rx_perr_o(rx_perr[1]), .rx_ferr_o(rx_ferr[1]),
`ifdef UART_XCVR_BREAK_DET_EN
      .rx_break_o(rx_break[1]),
`endif
      .tx_irq_i(tx_irq[1]), .tx_data_i(tx_data[1]), .tx_busy_o(tx_busy[1])
   );

   int compared = 0;
   int mismatched = 0;

   // ---------------- reference model ----------------
   function automatic int db_of(input int u);
      return (u == 0) ? 8 : 7;
   endfunction
   function automatic int par_of(input int u);
      return (u == 0) ? 0 : 2;
   endfunction
   function automatic int sb_of(input int u);
      return (u == 0) ? 1 : 2;
   endfunction
   function automatic int nbits_of(input int u);
      return 1 + db_of(u) + ((par_of(u) != 0) ? 1 : 0) + sb_of(u);
   endfunction

   // Line frame, first bit in bit 0; unused upper positions are idle (1).
   function automatic logic [15:0] frame_of(input int u, input logic [7:0] d,
                                             input logic flip_par, input logic flip_stop);
      logic [15:0] f;
      int k, ones;
      f = '1;
      f[0] = 1'b0;
      ones = 0;
      for (int i = 0; i < db_of(u); i++) begin
         f[1+i] = d[i];
         ones += int'(d[i]);
      end
      k = 1 + db_of(u);
      if (par_of(u) != 0) begin
         f[k] = ((ones % 2) == ((par_of(u) == 1) ? 0 : 1)) ^ flip_par;
         k++;
      end
      f[k] = ~flip_stop;
      return f;
   endfunction

   // What the receiver should report for a given line frame: {unit, ferr, perr, data}.
   function automatic logic [10:0] rx_exp(input int u, input logic [15:0] f);
      logic [7:0] d;
      int k, ones;
      logic perr;
      d = 8'h00;
      ones = 0;
      for (int i = 0; i < db_of(u); i++) begin
         d[i] = f[1+i];
         ones += int'(f[1+i]);
      end
      k = 1 + db_of(u);
      perr = 1'b0;
      if (par_of(u) != 0) begin
         ones += int'(f[k]);
         perr = (par_of(u) == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
         k++;
      end
      return {1'(u), ~f[k], perr, d};
   endfunction

   // ---------------- scoreboard ----------------
   logic [10:0] exp_q[$];
   logic [10:0] got_q[$];

   always @(negedge clk) begin
      if (rx_irq[0]) got_q.push_back({1'b0, rx_ferr[0], rx_perr[0], rx_data[0]});
      if (rx_irq[1]) got_q.push_back({1'b1, rx_ferr[1], rx_perr[1], rx_data[1]});
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic sb_check(input string tag);
      check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      while (got_q.size() > 0 && exp_q.size() > 0)
         check(tag, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
      got_q.delete();
      exp_q.delete();
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic rx_frame(input int u, input logic [15:0] f, input string tag);
      int n;
      n = nbits_of(u);
      exp_q.push_back(rx_exp(u, f));
      for (int k = 0; k < n; k++) begin
         uart_rx[u] = f[k];
         tick(DIV);
      end
      uart_rx[u] = 1'b1;
      tick(16);
      sb_check(tag);
   endtask

   // Sends d and samples the line at each bit centre; optionally fires a
   // second strobe with other data drop_at clocks into the frame.
   task automatic tx_frame(input int u, input logic [7:0] d, input int drop_at,
                           input logic [7:0] drop_d, input string tag);
      logic [15:0] cap, f;
      int n, j, busy_cnt;
      f = frame_of(u, d, 1'b0, 1'b0);
      n = nbits_of(u);
      cap = '1;
      busy_cnt = 0;
      j = 0;
      tx_data[u] = d;
      tx_irq[u] = 1'b1;
      tick(1);
      tx_irq[u] = 1'b0;
      tx_data[u] = 8'($urandom);
      while (tx_busy[u] && j < DIV * 16) begin
         if (j % DIV == DIV / 2) cap[j / DIV] = uart_tx[u];
         if (j == drop_at) begin
            tx_data[u] = drop_d;
            tx_irq[u] = 1'b1;
         end else begin
            tx_irq[u] = 1'b0;
         end
         busy_cnt++;
         j++;
         tick(1);
      end
      tx_irq[u] = 1'b0;
      check({tag, "_bits"}, 32'(cap), 32'(f));
      check({tag, "_busy"}, 32'(busy_cnt), 32'(DIV * n));
   endtask

   task automatic lb_frame(input int u, input logic [7:0] d, input int toggle_at,
                           input logic pin_noise, input string tag);
      int bad, n;
      n = nbits_of(u);
      loopback[u] = 1'b1;
      tick(4);
      exp_q.push_back(rx_exp(u, frame_of(u, d, 1'b0, 1'b0)));
      tx_data[u] = d;
      tx_irq[u] = 1'b1;
      tick(1);
      tx_irq[u] = 1'b0;
      bad = 0;
      for (int j = 0; j < DIV * n + 32; j++) begin
         if (uart_tx[u] !== 1'b1) bad++;
         if (pin_noise) uart_rx[u] = 1'((j >> 3) & 1);
         if (j == toggle_at) loopback[u] = 1'b0;
         tick(1);
      end
      check({tag, "_txhigh"}, 32'(bad), 32'd0);
      check({tag, "_idle"}, 32'(tx_busy[u]), 32'd0);
      sb_check(tag);
      uart_rx[u] = 1'b1;
      tick(4);
      loopback[u] = 1'b0;
      tick(4);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [7:0] d;
      logic fp, fs;
      int u;
      rst_n = 1'b0;
      uart_rx = '1;
      loopback = '0;
      tx_irq = '0;
      tx_data = '0;
      tick(3);
      check("rst_tx_line", 32'(uart_tx), 32'h3);
      check("rst_busy", 32'(tx_busy), 32'h0);
      check("rst_irq", 32'(rx_irq), 32'h0);
      check("rst_flags", 32'({rx_perr, rx_ferr}), 32'h0);
      check("rst_data", 32'(rx_data), 32'h0);
      rst_n = 1'b1;
      tick(4);
      check("idle_tx_line", 32'(uart_tx), 32'h3);
      check("idle_busy", 32'(tx_busy), 32'h0);

      // 8N1 receive and transmit
      rx_frame(0, frame_of(0, 8'hA5, 1'b0, 1'b0), "rx_a5");
      tx_frame(0, 8'h3C, -1, 8'h00, "tx_3c");

      // 7E2: bad parity bit, good parity bit, transmit with masked top bit
      rx_frame(1, frame_of(1, 8'h41, 1'b1, 1'b0), "rx_41_perr");
      rx_frame(1, frame_of(1, 8'h41, 1'b0, 1'b0), "rx_41_ok");
      tx_frame(1, 8'hC1, -1, 8'h00, "tx_41_7e2");

      // start-bit glitch gives nothing; stop=0 gives ferr with data
      uart_rx[0] = 1'b0;
      tick(DIV / 4);
      uart_rx[0] = 1'b1;
      tick(DIV);
      sb_check("glitch");
      rx_frame(0, frame_of(0, 8'h55, 1'b0, 1'b1), "rx_55_ferr");

      // busy handshake: dropped strobe, then back-to-back frame
      tx_frame(0, 8'h11, 100, 8'h22, "tx_11_drop");
      tx_frame(0, 8'h22, -1, 8'h00, "tx_22_b2b");
      tick(8);

      // loopback, with pin noise, then with a mid-frame mode change
      lb_frame(0, 8'h7E, -1, 1'b1, "lb_7e");
      lb_frame(0, 8'h7E, DIV * 3, 1'b0, "lb_toggle");

      // reset in the middle of a transmit
      tx_data[0] = 8'hC3;
      tx_irq[0] = 1'b1;
      tick(1);
      tx_irq[0] = 1'b0;
      tick(5 * DIV + DIV / 2);
      check("pre_rst_line", 32'(uart_tx[0]), 32'h0);
      check("pre_rst_busy", 32'(tx_busy[0]), 32'h1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_line", 32'(uart_tx[0]), 32'h1);
      check("mid_rst_busy", 32'(tx_busy[0]), 32'h0);
      check("mid_rst_data", 32'(rx_data[0]), 32'h0);
      tick(2);
      rst_n = 1'b1;
      tick(3);
      tx_frame(0, 8'h96, -1, 8'h00, "tx_after_rst");

      // randomized frames
      for (int r = 0; r < 3; r++) begin
         u = r % 2;
         d = 8'($urandom);
         fp = (par_of(u) != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
         fs = (u == 0 && d != 8'h00) ? 1'($urandom_range(0, 1)) : 1'b0;
         rx_frame(u, frame_of(u, d, fp, fs), "rand_rx");
      end
      for (int r = 0; r < 2; r++) begin
         tx_frame(r % 2, 8'($urandom), -1, 8'h00, "rand_tx");
      end
      tick(8);
      sb_check("tail");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
